// File: rtl/qu_rename_pkg.sv
// -----------------------------------------------------------------------------
// qu_rename_pkg
// Shared types for the rename stage and its neighbours.
//   uop_t          decoded uop as produced by decode (architectural operands)
//   renamed_uop_t  uop plus physical source/destination tags for dispatch
//   preg_t         physical register tag
// -----------------------------------------------------------------------------
package qu_rename_pkg;

    localparam int QU_ARCH_REGS = 32;
    localparam int QU_PHYS_REGS = 64;
    localparam int QU_PREG_W    = $clog2(QU_PHYS_REGS);

    typedef logic [4:0]           areg_t;
    typedef logic [QU_PREG_W-1:0] preg_t;

    typedef struct packed {
        areg_t rs1;
        areg_t rs2;
        areg_t rd;
        logic  rd_valid;
    } uop_t;

    typedef struct packed {
        uop_t  uop;
        preg_t ps1;
        preg_t ps2;
        preg_t prd;
        preg_t old_prd;
        logic  prd_valid;
    } renamed_uop_t;

endpackage

// File: rtl/qu_rename_free_list.sv
// -----------------------------------------------------------------------------
// qu_free_list
// Bit-vector physical register free list (bit set = register free).
//   clk, rst       clock, asynchronous active-high reset
//   alloc_i        take the lowest free register this cycle
//   alloc_idx_o    lowest free register (valid when !empty_o)
//   free_i         return free_idx_i to the list
//   free_idx_i     register being returned
//   load_i         overwrite the whole vector with load_vec_i (flush rebuild)
//   load_vec_i     rebuilt free vector
//   empty_o        no register free
//   vec_o          current free vector
// At reset registers ARCH_REGS..PHYS_REGS-1 are free; the low ones hold the
// identity mapping.
// -----------------------------------------------------------------------------
module qu_free_list
    import qu_rename_pkg::*;
#(
    parameter int PHYS_REGS  = QU_PHYS_REGS,
    parameter int ARCH_REGS  = QU_ARCH_REGS,
    parameter int PREG_WIDTH = $clog2(PHYS_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_i,
    output logic [PREG_WIDTH-1:0] alloc_idx_o,
    input  logic                  free_i,
    input  logic [PREG_WIDTH-1:0] free_idx_i,
    input  logic                  load_i,
    input  logic [PHYS_REGS-1:0]  load_vec_i,
    output logic                  empty_o,
    output logic [PHYS_REGS-1:0]  vec_o
);

    localparam logic [PHYS_REGS-1:0] RESET_VEC =
        {{(PHYS_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};

    logic [PHYS_REGS-1:0] vec_q, vec_d;

    // Lowest-index priority: scan from the top so the last hit wins.
    always_comb begin
        alloc_idx_o = '0;
        for (int i = PHYS_REGS - 1; i >= 0; i--) begin
            if (vec_q[i]) alloc_idx_o = PREG_WIDTH'(i);
        end
    end

    assign empty_o = ~|vec_q;
    assign vec_o   = vec_q;

    always_comb begin
        vec_d = vec_q;
        if (load_i) begin
            vec_d = load_vec_i;
        end else begin
            if (alloc_i) vec_d[alloc_idx_o] = 1'b0;
            if (free_i)  vec_d[free_idx_i]  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vec_q <= RESET_VEC;
        else     vec_q <= vec_d;
    end

endmodule

// File: rtl/qu_rename.sv
// -----------------------------------------------------------------------------
// qu_rename
// Register-rename stage between decode and dispatch. Maps architectural
// rs1/rs2/rd to physical tags using a speculative RAT, keeps a committed RAT
// for recovery, and allocates destinations from a bit-vector free list.
// Results leave through a single output register (1-cycle latency).
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    squash output, rebuild speculative state
//   in_valid/in_ready        decoded uop handshake, in_nop marks a nop
//   uop_in                   decoded uop
//   out_valid/out_ready      renamed uop handshake toward dispatch
//   uop_out                  renamed uop
//   commit_valid/rd/prd/old_prd  retirement: update committed RAT, free old_prd
// Optional feature macro: QU_RENAME_FREE_BYPASS_EN -- when the free list is
// empty, a retiring old_prd is handed straight to a same-cycle allocation.
// -----------------------------------------------------------------------------
module qu_rename
    import qu_rename_pkg::*;
#(
    parameter int ARCH_REGS  = QU_ARCH_REGS,
    parameter int PHYS_REGS  = QU_PHYS_REGS,
    parameter int PREG_WIDTH = $clog2(PHYS_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_nop,
    input  uop_t                  uop_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output renamed_uop_t          uop_out,
    input  logic                  commit_valid,
    input  logic [4:0]            commit_rd,
    input  logic [PREG_WIDTH-1:0] commit_prd,
    input  logic [PREG_WIDTH-1:0] commit_old_prd
);

    preg_t spec_rat_q [ARCH_REGS];
    preg_t spec_rat_d [ARCH_REGS];
    preg_t comm_rat_q [ARCH_REGS];
    preg_t comm_rat_d [ARCH_REGS];

    logic         out_valid_q, out_valid_d;
    renamed_uop_t uop_out_q, uop_out_d;

    logic                  need_alloc;
    logic                  bypass_avail;
    logic                  use_bypass;
    logic                  can_alloc;
    logic                  out_drain;
    logic                  fire;
    logic                  alloc_fire;
    logic                  fl_alloc;
    logic                  fl_free;
    logic                  fl_empty;
    logic [PREG_WIDTH-1:0] fl_idx;
    logic [PHYS_REGS-1:0]  fl_vec;
    logic [PHYS_REGS-1:0]  mapped_vec;
    preg_t                 new_prd;

    assign need_alloc = uop_in.rd_valid && (uop_in.rd != 5'd0) && !in_nop;

`ifdef QU_RENAME_FREE_BYPASS_EN
    // p0 never circulates, so a retiring p0 cannot feed the bypass.
    assign bypass_avail = fl_empty && commit_valid && (commit_old_prd != '0);
`else
    assign bypass_avail = 1'b0;
`endif

    assign can_alloc  = !fl_empty || bypass_avail;
    assign out_drain  = !out_valid_q || out_ready;
    assign in_ready   = !flush && out_drain && (!need_alloc || can_alloc);
    assign fire       = in_valid && in_ready;
    assign alloc_fire = fire && need_alloc;
    assign use_bypass = alloc_fire && bypass_avail;
    assign new_prd    = use_bypass ? preg_t'(commit_old_prd) : preg_t'(fl_idx);

    // A bypassed register goes straight to the new uop, so it is not also
    // marked free.
    assign fl_alloc = alloc_fire && !use_bypass;
    assign fl_free  = commit_valid && (commit_old_prd != '0) && !use_bypass;

    // Committed RAT including this cycle's commit; a flush restores from it.
    always_comb begin
        comm_rat_d = comm_rat_q;
        if (commit_valid && (commit_rd != 5'd0)) begin
            comm_rat_d[commit_rd] = preg_t'(commit_prd);
        end
    end

    // Every preg referenced by the committed RAT is live; the rest are free.
    always_comb begin
        mapped_vec = '0;
        for (int i = 0; i < ARCH_REGS; i++) begin
            mapped_vec[comm_rat_d[i]] = 1'b1;
        end
    end

    always_comb begin
        spec_rat_d = spec_rat_q;
        if (flush) begin
            spec_rat_d = comm_rat_d;
        end else if (alloc_fire) begin
            spec_rat_d[uop_in.rd] = new_prd;
        end
    end

    // Sources read the pre-update RAT, so rs==rd sees the old mapping.
    always_comb begin
        out_valid_d = out_valid_q;
        uop_out_d   = uop_out_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (fire && !in_nop) begin
            out_valid_d         = 1'b1;
            uop_out_d.uop       = uop_in;
            uop_out_d.ps1       = spec_rat_q[uop_in.rs1];
            uop_out_d.ps2       = spec_rat_q[uop_in.rs2];
            uop_out_d.prd_valid = need_alloc;
            uop_out_d.prd       = need_alloc ? new_prd : '0;
            uop_out_d.old_prd   = need_alloc ? spec_rat_q[uop_in.rd] : '0;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    qu_free_list #(
        .PHYS_REGS  (PHYS_REGS),
        .ARCH_REGS  (ARCH_REGS),
        .PREG_WIDTH (PREG_WIDTH)
    ) u_fl (
        .clk         (clk),
        .rst         (rst),
        .alloc_i     (fl_alloc),
        .alloc_idx_o (fl_idx),
        .free_i      (fl_free),
        .free_idx_i  (commit_old_prd),
        .load_i      (flush),
        .load_vec_i  (~mapped_vec),
        .empty_o     (fl_empty),
        .vec_o       (fl_vec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                spec_rat_q[i] <= preg_t'(i);
                comm_rat_q[i] <= preg_t'(i);
            end
        end else begin
            spec_rat_q <= spec_rat_d;
            comm_rat_q <= comm_rat_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            uop_out_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            uop_out_q   <= uop_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign uop_out   = uop_out_q;

endmodule

// File: tb/tb_qu_rename.sv
// -----------------------------------------------------------------------------
// tb_qu_rename -- directed bench for qu_rename.
// Honours QU_RENAME_FREE_BYPASS_EN when defined for the whole build.
// -----------------------------------------------------------------------------
module tb_qu_rename;
    import qu_rename_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic         in_nop;
    uop_t         uop_in;
    logic         out_valid;
    logic         out_ready;
    renamed_uop_t uop_out;
    logic         commit_valid;
    logic [4:0]   commit_rd;
    preg_t        commit_prd;
    preg_t        commit_old_prd;

    int n_cmp = 0;
    int n_bad = 0;

    qu_rename dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_nop         (in_nop),
        .uop_in         (uop_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .uop_out        (uop_out),
        .commit_valid   (commit_valid),
        .commit_rd      (commit_rd),
        .commit_prd     (commit_prd),
        .commit_old_prd (commit_old_prd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_uop(input int rs1, input int rs2, input int rd, input logic rdv);
        uop_in.rs1      = 5'(rs1);
        uop_in.rs2      = 5'(rs2);
        uop_in.rd       = 5'(rd);
        uop_in.rd_valid = rdv;
    endtask

    task automatic do_reset();
        flush          = 1'b0;
        in_valid       = 1'b0;
        in_nop         = 1'b0;
        out_ready      = 1'b1;
        commit_valid   = 1'b0;
        commit_rd      = '0;
        commit_prd     = '0;
        commit_old_prd = '0;
        set_uop(0, 0, 0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int stalls;

        // Reset state
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_uop_out", 64'(uop_out), 64'd0);
        chk("rst_free_vec", dut.u_fl.vec_q, 64'hFFFFFFFF_00000000);
        chk("rst_spec_rat31", 64'(dut.spec_rat_q[31]), 64'd31);

        // 1: x5 = x1 + x2
        set_uop(1, 2, 5, 1'b1);
        in_valid = 1'b1;
        #1;
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_ps1", 64'(uop_out.ps1), 64'd1);
        chk("t1_ps2", 64'(uop_out.ps2), 64'd2);
        chk("t1_prd", 64'(uop_out.prd), 64'd32);
        chk("t1_old_prd", 64'(uop_out.old_prd), 64'd5);
        chk("t1_prd_valid", 64'(uop_out.prd_valid), 64'd1);

        // rs == rd reads the old mapping
        set_uop(5, 0, 5, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_rsrd_ps1", 64'(uop_out.ps1), 64'd32);
        chk("t1_rsrd_prd", 64'(uop_out.prd), 64'd33);
        chk("t1_rsrd_old", 64'(uop_out.old_prd), 64'd32);

        // 2: rd=x0, rd_valid=0, nop
        set_uop(5, 0, 0, 1'b1);
        in_valid = 1'b1;
        tick();
        chk("t2_x0_prd_valid", 64'(uop_out.prd_valid), 64'd0);
        chk("t2_x0_prd", 64'(uop_out.prd), 64'd0);
        chk("t2_x0_ps1", 64'(uop_out.ps1), 64'd33);
        set_uop(1, 0, 7, 1'b0);
        tick();
        chk("t2_nordv_prd_valid", 64'(uop_out.prd_valid), 64'd0);
        chk("t2_nordv_old", 64'(uop_out.old_prd), 64'd0);
        set_uop(1, 0, 7, 1'b1);
        in_nop = 1'b1;
        tick();
        in_nop   = 1'b0;
        in_valid = 1'b0;
        chk("t2_nop_out_valid", 64'(out_valid), 64'd0);
        chk("t2_free_vec", dut.u_fl.vec_q, 64'hFFFFFFFC_00000000);

        // 3: exhaust the free list
        do_reset();
        stalls = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 32; k++) begin
            set_uop(0, 0, (k % 31) + 1, 1'b1);
            #1;
            if (!in_ready) stalls++;
            tick();
        end
        chk("t3_fill_stalls", 64'(stalls), 64'd0);
        set_uop(0, 0, 9, 1'b1);
        #1;
        chk("t3_full_in_ready", 64'(in_ready), 64'd0);
        chk("t3_free_vec_empty", dut.u_fl.vec_q, 64'd0);
        commit_valid   = 1'b1;
        commit_rd      = 5'd5;
        commit_prd     = 6'd36;
        commit_old_prd = 6'd5;
        #1;
`ifdef QU_RENAME_FREE_BYPASS_EN
        chk("t3_commit_cycle_ready", 64'(in_ready), 64'd1);
        tick();
        commit_valid = 1'b0;
        in_valid     = 1'b0;
`else
        chk("t3_commit_cycle_ready", 64'(in_ready), 64'd0);
        tick();
        commit_valid = 1'b0;
        #1;
        chk("t3_after_commit_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
`endif
        chk("t3_out_valid", 64'(out_valid), 64'd1);
        chk("t3_prd", 64'(uop_out.prd), 64'd5);
        chk("t3_old_prd", 64'(uop_out.old_prd), 64'd40);

        // 4: output backpressure
        do_reset();
        out_ready = 1'b0;
        set_uop(1, 0, 3, 1'b1);
        in_valid = 1'b1;
        tick();
        set_uop(2, 0, 4, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t4_stall_in_ready", 64'(in_ready), 64'd0);
            chk("t4_stall_out_valid", 64'(out_valid), 64'd1);
            chk("t4_stall_prd", 64'(uop_out.prd), 64'd32);
            chk("t4_stall_rd", 64'(uop_out.uop.rd), 64'd3);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("t4_release_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("t4_next_prd", 64'(uop_out.prd), 64'd33);
        chk("t4_next_old", 64'(uop_out.old_prd), 64'd4);
        chk("t4_next_ps1", 64'(uop_out.ps1), 64'd2);

        // 5 + 6: two renames of x5, then commit + flush with a uop offered
        do_reset();
        set_uop(0, 0, 5, 1'b1);
        in_valid = 1'b1;
        tick();
        tick();
        chk("t5_second_prd", 64'(uop_out.prd), 64'd33);
        chk("t5_second_old", 64'(uop_out.old_prd), 64'd32);
        set_uop(0, 0, 6, 1'b1);
        flush          = 1'b1;
        commit_valid   = 1'b1;
        commit_rd      = 5'd5;
        commit_prd     = 6'd32;
        commit_old_prd = 6'd5;
        #1;
        chk("t6_flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush        = 1'b0;
        commit_valid = 1'b0;
        in_valid     = 1'b0;
        chk("t6_flush_out_valid", 64'(out_valid), 64'd0);
        chk("t6_spec_rat6", 64'(dut.spec_rat_q[6]), 64'd6);
        chk("t5_spec_rat5", 64'(dut.spec_rat_q[5]), 64'd32);
        chk("t5_comm_rat5", 64'(dut.comm_rat_q[5]), 64'd32);
        chk("t5_free_p32", 64'(dut.u_fl.vec_q[32]), 64'd0);
        chk("t5_free_p33", 64'(dut.u_fl.vec_q[33]), 64'd1);
        chk("t5_free_vec", dut.u_fl.vec_q, 64'hFFFFFFFE_00000020);
        set_uop(5, 0, 7, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t5_post_ps1", 64'(uop_out.ps1), 64'd32);
        chk("t5_post_prd", 64'(uop_out.prd), 64'd5);
        chk("t5_post_old", 64'(uop_out.old_prd), 64'd7);

        // 7: asynchronous reset while stalled
        do_reset();
        out_ready = 1'b0;
        set_uop(0, 0, 5, 1'b1);
        in_valid = 1'b1;
        tick();
        set_uop(0, 0, 6, 1'b1);
        chk("t7_pre_out_valid", 64'(out_valid), 64'd1);
        chk("t7_pre_spec_rat5", 64'(dut.spec_rat_q[5]), 64'd32);
        #2;
        rst = 1'b1;
        #1;
        chk("t7_out_valid", 64'(out_valid), 64'd0);
        chk("t7_uop_out", 64'(uop_out), 64'd0);
        chk("t7_spec_rat5", 64'(dut.spec_rat_q[5]), 64'd5);
        chk("t7_free_vec", dut.u_fl.vec_q, 64'hFFFFFFFF_00000000);
        in_valid = 1'b0;
        #1;
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
